rv32i_host_loader: RTL and testbench
====================================

Name: rv32i_host_loader

Overview:
- Synthesizable host-side boot controller for the RV32I single-cycle core. It drives the core's CFG (instruction memory) and LDM (data memory) load ports and its start line.
- It accepts a valid/ready stream of 64-bit {addr,data} records and loads LDM_COUNT data words, then CFG_COUNT instruction words. It then asserts start and waits for the core's Met_jr_ra indication.
- After Met_jr_ra, it polls data memory at DONE_ADDR until the value equals DONE_VALUE, then stops the core and flags completion.
- It replaces the simulation-only load and monitor sequence with hardware usable on the FPGA target.

Parameters:
- LDM_COUNT, 18, number of data-memory records loaded first (0 skips the LDM phase).
- CFG_COUNT, 64, number of instruction records loaded second (0 skips the CFG phase).
- DONE_ADDR, 32'h00000000, LDM address polled for the completion flag.
- DONE_VALUE, 32'h00000001, flag value that signals program completion.
- TIMEOUT_CYCLES, 1000000, maximum cycles in RUN+POLL before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- go_in  in  1  begin a load/run sequence; honoured only in IDLE, DONE, TIMEOUT.
- rec_valid_in  in  1  record valid.
- rec_ready_out  out  1  record ready.
- rec_data_in  in  64  record, [63:32] = address, [31:0] = data.
- LDM_wea_out  out  1  data-memory write enable.
- LDM_addra_out  out  32  data-memory address (write and poll read).
- LDM_dina_out  out  32  data-memory write data.
- LDM_douta_in  in  32  data-memory read data; valid 1 cycle after address presented.
- CFG_wea_out  out  1  instruction-memory write enable.
- CFG_addr_out  out  32  instruction-memory address.
- CFG_dina_out  out  32  instruction-memory write data.
- Met_jr_ra_in  in  1  core reached final jr ra.
- start_out  out  1  core run enable.
- busy_out  out  1  high in every state except IDLE, DONE, TIMEOUT.
- done_out  out  1  sticky completion flag.
- timeout_out  out  1  sticky timeout flag.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs go to 0, including addresses and data.
  - Record counter, timeout counter and Met latch are cleared.
  - Reset mid-operation aborts immediately; a partial load is not resumed.
- Outputs: all are registered except rec_ready_out, which decodes state (high only in LOAD_LDM and LOAD_CFG).
- Record acceptance: a record is accepted on a rising edge with rec_valid_in && rec_ready_out.
  - The write appears on the target port the next cycle, with wea=1 for exactly 1 cycle and addr/data taken from the record.
  - wea is 0 in every other cycle.
  - One record may be accepted per cycle, giving back-to-back writes.
  - rec_valid_in is ignored outside the load states.
- States:
  - IDLE: on go_in, clear done_out, timeout_out and counters, then go to LOAD_LDM (or LOAD_CFG if LDM_COUNT=0, or RUN if both counts are 0).
  - LOAD_LDM: count acceptances. On acceptance number LDM_COUNT go to GAP_LDM.
  - GAP_LDM: 1 cycle; the last LDM write is on the bus. Then go to LOAD_CFG, or to RUN if CFG_COUNT=0. LDM_wea and CFG_wea are never high in the same cycle, and at least 1 idle cycle separates the phases.
  - LOAD_CFG: count acceptances. On acceptance number CFG_COUNT go to GAP_CFG.
  - GAP_CFG: 1 cycle carrying the last CFG write. Then go to RUN with start_out=1 registered, so the first RUN cycle has start_out=1.
  - RUN: start_out=1. When Met_jr_ra_in=1, set the sticky Met latch, drive LDM_addra_out=DONE_ADDR and go to POLL_WAIT.
  - POLL_WAIT: 1 cycle for read latency. Go to POLL_CHK.
  - POLL_CHK: if LDM_douta_in==DONE_VALUE, go to DONE. Otherwise return to POLL_WAIT, re-polling every 2 cycles while start_out stays 1.
  - DONE: start_out=0, done_out=1. Hold until go_in.
  - TIMEOUT: start_out=0, timeout_out=1. Hold until go_in.
- Timeout:
  - The counter increments on every cycle in RUN, POLL_WAIT and POLL_CHK.
  - When it reaches TIMEOUT_CYCLES, go to TIMEOUT.
  - If the timeout and a DONE_VALUE match occur in the same cycle, DONE wins.
- Met_jr_ra_in:
  - A 1-cycle pulse is sufficient because it is latched.
  - It is ignored outside RUN.
- go_in: ignored while busy_out=1. A go_in from DONE or TIMEOUT restarts the full sequence, clearing the sticky flags.
- Addresses are passed through unmodified, with no range check; a duplicate address is simply rewritten.

Test Plan:
- Nominal load, LDM_COUNT=2, CFG_COUNT=3, valid held high: send records 0000000000000005, 0000000400000007, then 0000000000000013, 0000000400100093, 0000000800208113.
  - LDM_wea pulses 2 consecutive cycles with the correct addr/data.
  - Exactly 1 idle cycle follows.
  - CFG_wea pulses 3 cycles.
  - start_out rises the cycle after GAP_CFG.
- Valid stalls: toggle rec_valid_in 1/0 during the LDM phase.
  - A write is issued only for accepted records, each 1 cycle after acceptance.
  - The count reaches exactly 2 before moving on.
- Completion: Met_jr_ra_in pulses for 1 cycle, LDM_douta_in returns 0 on the first poll and 1 on the second.
  - LDM_addra_out=0.
  - start_out falls and done_out=1 after the second POLL_CHK.
  - busy_out=0.
- Timeout: TIMEOUT_CYCLES=20, Met_jr_ra_in never asserted.
  - timeout_out=1 and start_out=0 exactly 20 cycles after entering RUN.
  - A later go_in clears the flag and reloads.
- Reset mid-load: assert rst_n=0 after 1 of 3 CFG writes.
  - All outputs are 0 immediately, asynchronously.
  - After release, state is IDLE and go_in restarts from the LDM phase.
- Zero-count corner: LDM_COUNT=0, CFG_COUNT=0, go_in pulsed.
  - start_out=1 the next cycle.
  - No wea pulses.
  - rec_ready_out stays 0.

Source files
------------

// File: rtl/rv32i_host_loader.sv
// Host-side boot controller for the RV32I single-cycle core.
// Streams {addr,data} records into data memory (LDM) and then instruction
// memory (CFG), starts the core, waits for the final jr ra, then polls a
// completion word in data memory. A cycle budget bounds the run and poll time.
module rv32i_host_loader #(
  parameter int unsigned LDM_COUNT      = 18,
  parameter int unsigned CFG_COUNT      = 64,
  parameter logic [31:0] DONE_ADDR      = 32'h0000_0000,
  parameter logic [31:0] DONE_VALUE     = 32'h0000_0001,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go_in,
  input  logic        rec_valid_in,
  output logic        rec_ready_out,
  input  logic [63:0] rec_data_in,
  output logic        LDM_wea_out,
  output logic [31:0] LDM_addra_out,
  output logic [31:0] LDM_dina_out,
  input  logic [31:0] LDM_douta_in,
  output logic        CFG_wea_out,
  output logic [31:0] CFG_addr_out,
  output logic [31:0] CFG_dina_out,
  input  logic        Met_jr_ra_in,
  output logic        start_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        timeout_out
);

  // Record counter is shared by both load phases, so size it for the larger.
  localparam int unsigned MAXC = (LDM_COUNT > CFG_COUNT) ? LDM_COUNT : CFG_COUNT;
  localparam int unsigned RCW  = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT_CYCLES + 1);

  // Index of the final record of each phase. A zero-count phase is never
  // entered, so the wrapped value for a count of 0 is never compared.
  localparam logic [RCW-1:0] LDM_LAST  = RCW'(LDM_COUNT - 1);
  localparam logic [RCW-1:0] CFG_LAST  = RCW'(CFG_COUNT - 1);
  localparam logic [TW-1:0]  TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_LDM,
    S_GAP_LDM,
    S_LOAD_CFG,
    S_GAP_CFG,
    S_RUN,
    S_POLL_WAIT,
    S_POLL_CHK,
    S_DONE,
    S_TIMEOUT
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;

  // First state after go, skipping empty phases.
  localparam state_e FIRST_STATE = (LDM_COUNT != 0) ? S_LOAD_LDM :
                                   (CFG_COUNT != 0) ? S_LOAD_CFG : S_RUN;
  // State following the LDM gap cycle.
  localparam state_e AFTER_LDM   = (CFG_COUNT != 0) ? S_LOAD_CFG : S_RUN;

  state_e          state_q, state_d;
  logic [RCW-1:0]  rec_cnt_q, rec_cnt_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic            met_q, met_d;

  logic            ldm_wea_q, ldm_wea_d;
  logic [31:0]     ldm_addr_q, ldm_addr_d;
  logic [31:0]     ldm_din_q, ldm_din_d;
  logic            cfg_wea_q, cfg_wea_d;
  logic [31:0]     cfg_addr_q, cfg_addr_d;
  logic [31:0]     cfg_din_q, cfg_din_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            timeout_q, timeout_d;

  rec_t            rec;
  logic            accept;
  logic            in_run;
  logic            poll_hit;
  logic [TW-1:0]   tmo_inc;

  assign rec = rec_t'(rec_data_in);

  // Ready is the only combinational output: it is a pure state decode.
  assign rec_ready_out = (state_q == S_LOAD_LDM) || (state_q == S_LOAD_CFG);
  assign accept        = rec_valid_in && rec_ready_out;

  // Run-time states share the timeout budget.
  assign in_run   = (state_q == S_RUN) || (state_q == S_POLL_WAIT) ||
                    (state_q == S_POLL_CHK);
  assign tmo_inc  = tmo_cnt_q + TW'(1);
  assign poll_hit = (state_q == S_POLL_CHK) && (LDM_douta_in == DONE_VALUE);

  // Next-state, counters and registered port values.
  always_comb begin
    state_d    = state_q;
    rec_cnt_d  = rec_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    met_d      = met_q;
    ldm_wea_d  = 1'b0;
    ldm_addr_d = ldm_addr_q;
    ldm_din_d  = ldm_din_q;
    cfg_wea_d  = 1'b0;
    cfg_addr_d = cfg_addr_q;
    cfg_din_d  = cfg_din_q;

    case (state_q)
      S_IDLE, S_DONE, S_TIMEOUT: begin
        if (go_in) begin
          state_d   = FIRST_STATE;
          rec_cnt_d = '0;
          tmo_cnt_d = '0;
          met_d     = 1'b0;
        end
      end
      S_LOAD_LDM: begin
        if (accept) begin
          ldm_wea_d  = 1'b1;
          ldm_addr_d = rec.addr;
          ldm_din_d  = rec.data;
          if (rec_cnt_q == LDM_LAST) begin
            rec_cnt_d = '0;
            state_d   = S_GAP_LDM;
          end else begin
            rec_cnt_d = rec_cnt_q + RCW'(1);
          end
        end
      end
      // Last LDM write is on the bus; keeps the two write ports apart.
      S_GAP_LDM: state_d = AFTER_LDM;
      S_LOAD_CFG: begin
        if (accept) begin
          cfg_wea_d  = 1'b1;
          cfg_addr_d = rec.addr;
          cfg_din_d  = rec.data;
          if (rec_cnt_q == CFG_LAST) begin
            rec_cnt_d = '0;
            state_d   = S_GAP_CFG;
          end else begin
            rec_cnt_d = rec_cnt_q + RCW'(1);
          end
        end
      end
      S_GAP_CFG: state_d = S_RUN;
      S_RUN: begin
        tmo_cnt_d = tmo_inc;
        if (Met_jr_ra_in || met_q) begin
          met_d      = 1'b1;
          ldm_addr_d = DONE_ADDR;
          state_d    = S_POLL_WAIT;
        end
      end
      // Address already presented; douta is valid in the following cycle.
      S_POLL_WAIT: begin
        tmo_cnt_d = tmo_inc;
        state_d   = S_POLL_CHK;
      end
      S_POLL_CHK: begin
        tmo_cnt_d = tmo_inc;
        state_d   = S_POLL_WAIT;
      end
      default: state_d = S_IDLE;
    endcase

    // Budget exhausted aborts the run, but a completion seen in the same
    // cycle takes priority.
    if (in_run && (tmo_inc == TMO_LIMIT)) state_d = S_TIMEOUT;
    if (poll_hit) state_d = S_DONE;
  end

  // Status outputs are registered decodes of the next state, so start is
  // already high in the first RUN cycle and the flags are sticky until go.
  always_comb begin
    start_d   = (state_d == S_RUN) || (state_d == S_POLL_WAIT) ||
                (state_d == S_POLL_CHK);
    busy_d    = !((state_d == S_IDLE) || (state_d == S_DONE) ||
                  (state_d == S_TIMEOUT));
    done_d    = (state_d == S_DONE);
    timeout_d = (state_d == S_TIMEOUT);
  end

  // State register and all registered outputs; reset aborts everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rec_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      met_q      <= 1'b0;
      ldm_wea_q  <= 1'b0;
      ldm_addr_q <= '0;
      ldm_din_q  <= '0;
      cfg_wea_q  <= 1'b0;
      cfg_addr_q <= '0;
      cfg_din_q  <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_cnt_q  <= rec_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      met_q      <= met_d;
      ldm_wea_q  <= ldm_wea_d;
      ldm_addr_q <= ldm_addr_d;
      ldm_din_q  <= ldm_din_d;
      cfg_wea_q  <= cfg_wea_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_din_q  <= cfg_din_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  assign LDM_wea_out   = ldm_wea_q;
  assign LDM_addra_out = ldm_addr_q;
  assign LDM_dina_out  = ldm_din_q;
  assign CFG_wea_out   = cfg_wea_q;
  assign CFG_addr_out  = cfg_addr_q;
  assign CFG_dina_out  = cfg_din_q;
  assign start_out     = start_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign timeout_out   = timeout_q;

endmodule

// File: tb/tb_rv32i_host_loader.sv
// Directed bench for rv32i_host_loader: a 2-LDM/3-CFG instance with a
// 20-cycle budget, plus a zero-count instance for the empty-load corner.
module tb_rv32i_host_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        go = 1'b0, vld = 1'b0, met = 1'b0;
  logic [63:0] rdat = '0;
  logic [31:0] dout = '0;
  logic        rdy, lwe, cwe, st, bsy, dn, to;
  logic [31:0] la, ld, ca, cd;

  rv32i_host_loader #(
    .LDM_COUNT(2), .CFG_COUNT(3), .DONE_ADDR(32'h0), .DONE_VALUE(32'h1),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .go_in(go), .rec_valid_in(vld),
    .rec_ready_out(rdy), .rec_data_in(rdat),
    .LDM_wea_out(lwe), .LDM_addra_out(la), .LDM_dina_out(ld),
    .LDM_douta_in(dout),
    .CFG_wea_out(cwe), .CFG_addr_out(ca), .CFG_dina_out(cd),
    .Met_jr_ra_in(met), .start_out(st), .busy_out(bsy),
    .done_out(dn), .timeout_out(to)
  );

  // Zero-count instance; valid held high to show it is ignored.
  logic        go_z = 1'b0;
  logic        z_rdy, z_lwe, z_cwe, z_st, z_bsy, z_dn, z_to;
  logic [31:0] z_la, z_ld, z_ca, z_cd;

  rv32i_host_loader #(
    .LDM_COUNT(0), .CFG_COUNT(0), .DONE_ADDR(32'h0), .DONE_VALUE(32'h1),
    .TIMEOUT_CYCLES(20)
  ) dut_z (
    .clk(clk), .rst_n(rst_n), .go_in(go_z), .rec_valid_in(1'b1),
    .rec_ready_out(z_rdy), .rec_data_in(64'h0000_0020_DEAD_BEEF),
    .LDM_wea_out(z_lwe), .LDM_addra_out(z_la), .LDM_dina_out(z_ld),
    .LDM_douta_in(32'h0),
    .CFG_wea_out(z_cwe), .CFG_addr_out(z_ca), .CFG_dina_out(z_cd),
    .Met_jr_ra_in(1'b0), .start_out(z_st), .busy_out(z_bsy),
    .done_out(z_dn), .timeout_out(z_to)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {LDM_wea, CFG_wea, start, busy, done, timeout, ready}
  function automatic logic [6:0] ctl_a();
    return {lwe, cwe, st, bsy, dn, to, rdy};
  endfunction

  function automatic logic [6:0] ctl_z();
    return {z_lwe, z_cwe, z_st, z_bsy, z_dn, z_to, z_rdy};
  endfunction

  typedef struct {
    logic        go;
    logic        vld;
    logic [63:0] rec;
    logic        met;
    logic [31:0] dout;
    logic [6:0]  ctl;
    logic [63:0] ldm;   // {addr, data}
    logic [63:0] cfg;   // {addr, data}
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic g, input logic v, input logic [63:0] r,
                     input logic m, input logic [31:0] d, input logic [6:0] c,
                     input logic [63:0] l, input logic [63:0] f);
    vec_t t;
    t.go = g; t.vld = v; t.rec = r; t.met = m; t.dout = d;
    t.ctl = c; t.ldm = l; t.cfg = f;
    vq.push_back(t);
  endtask

  logic [63:0] recs [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   idx;
    recs[0] = 64'h0000_0000_0000_0005;
    recs[1] = 64'h0000_0004_0000_0007;
    recs[2] = 64'h0000_0000_0000_0013;
    recs[3] = 64'h0000_0004_0010_0093;
    recs[4] = 64'h0000_0008_0020_8113;

    // Nominal load, then Met pulse and two polls (0 then 1).
    //   go vld rec       met dout   ctl         ldm                      cfg
    add(1, 0, 64'h0,    0, 32'h0, 7'b0001001, 64'h0,                   64'h0);
    add(0, 1, recs[0],  0, 32'h0, 7'b1001001, 64'h0000_0000_0000_0005, 64'h0);
    add(0, 1, recs[1],  0, 32'h0, 7'b1001000, 64'h0000_0004_0000_0007, 64'h0);
    add(0, 1, recs[2],  0, 32'h0, 7'b0001001, 64'h0000_0004_0000_0007, 64'h0);
    add(0, 1, recs[2],  0, 32'h0, 7'b0101001, 64'h0000_0004_0000_0007, 64'h0000_0000_0000_0013);
    add(0, 1, recs[3],  0, 32'h0, 7'b0101001, 64'h0000_0004_0000_0007, 64'h0000_0004_0010_0093);
    add(0, 1, recs[4],  0, 32'h0, 7'b0101000, 64'h0000_0004_0000_0007, 64'h0000_0008_0020_8113);
    add(0, 0, 64'h0,    0, 32'h0, 7'b0011000, 64'h0000_0004_0000_0007, 64'h0000_0008_0020_8113);
    add(0, 0, 64'h0,    1, 32'h0, 7'b0011000, 64'h0000_0000_0000_0007, 64'h0000_0008_0020_8113);
    add(0, 0, 64'h0,    0, 32'h0, 7'b0011000, 64'h0000_0000_0000_0007, 64'h0000_0008_0020_8113);
    add(0, 0, 64'h0,    0, 32'h0, 7'b0011000, 64'h0000_0000_0000_0007, 64'h0000_0008_0020_8113);
    add(0, 0, 64'h0,    0, 32'h0, 7'b0011000, 64'h0000_0000_0000_0007, 64'h0000_0008_0020_8113);
    add(0, 0, 64'h0,    0, 32'h1, 7'b0000100, 64'h0000_0000_0000_0007, 64'h0000_0008_0020_8113);
    add(0, 0, 64'h0,    0, 32'h0, 7'b0000100, 64'h0000_0000_0000_0007, 64'h0000_0008_0020_8113);

    // Reset state
    #12;
    chk("rst_ctl", {57'h0, ctl_a()}, 64'h0);
    chk("rst_ldm", {la, ld}, 64'h0);
    chk("rst_cfg", {ca, cd}, 64'h0);
    chk("rst_z_ctl", {57'h0, ctl_z()}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ctl", {57'h0, ctl_a()}, 64'h0);

    // Table-driven nominal run
    foreach (vq[i]) begin
      go = vq[i].go; vld = vq[i].vld; rdat = vq[i].rec;
      met = vq[i].met; dout = vq[i].dout;
      tick();
      chk($sformatf("vec%0d_ctl", i), {57'h0, ctl_a()}, {57'h0, vq[i].ctl});
      chk($sformatf("vec%0d_ldm", i), {la, ld}, vq[i].ldm);
      chk($sformatf("vec%0d_cfg", i), {ca, cd}, vq[i].cfg);
    end
    go = 0; vld = 0; met = 0; dout = 0;

    // Timeout: restart from DONE, reload, never send Met.
    go = 1;
    tick();
    go = 0;
    chk("go_clears_done", {61'h0, dn, bsy, rdy}, {61'h0, 3'b011});
    seen = 1'b0;
    idx = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      vld = 1'b1;
      rdat = recs[(idx < 5) ? idx : 4];
      if (rdy && idx < 5) idx++;
      tick();
      if (st) seen = 1'b1;
    end
    vld = 1'b0;
    chk("tmo_run_reached", {63'h0, seen}, 64'h1);
    for (int c = 1; c < 20; c++) begin
      tick();
      chk($sformatf("tmo_wait%0d", c), {62'h0, st, to}, {62'h0, 2'b10});
    end
    tick();
    chk("tmo_hit", {61'h0, st, to, bsy}, {61'h0, 3'b010});
    go = 1;
    tick();
    go = 0;
    chk("go_clears_tmo", {61'h0, to, bsy, rdy}, {61'h0, 3'b011});

    // Valid stalls during the LDM phase: {LDM_wea, CFG_wea, ready}
    vld = 1; rdat = 64'h0000_0010_0000_00AA;
    tick();
    chk("stall_w1", {61'h0, lwe, cwe, rdy}, {61'h0, 3'b101});
    chk("stall_a1", {la, ld}, 64'h0000_0010_0000_00AA);
    vld = 0;
    tick();
    chk("stall_gap", {61'h0, lwe, cwe, rdy}, {61'h0, 3'b001});
    vld = 1; rdat = 64'h0000_0014_0000_00BB;
    tick();
    chk("stall_w2", {61'h0, lwe, cwe, rdy}, {61'h0, 3'b100});
    chk("stall_a2", {la, ld}, 64'h0000_0014_0000_00BB);
    rdat = 64'h0000_0000_0000_0013;
    tick();
    chk("phase_gap", {61'h0, lwe, cwe, rdy}, {61'h0, 3'b001});
    tick();
    chk("cfg_w1", {61'h0, lwe, cwe, rdy}, {61'h0, 3'b011});
    chk("cfg_a1", {ca, cd}, 64'h0000_0000_0000_0013);
    vld = 0;

    // Reset mid-load is asynchronous and clears every output.
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ctl", {57'h0, ctl_a()}, 64'h0);
    chk("arst_ldm", {la, ld}, 64'h0);
    chk("arst_cfg", {ca, cd}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", {57'h0, ctl_a()}, 64'h0);
    go = 1;
    tick();
    go = 0;
    chk("restart_go", {57'h0, ctl_a()}, {57'h0, 7'b0001001});
    vld = 1; rdat = 64'h0000_0030_0000_00CC;
    tick();
    vld = 0;
    chk("restart_ldm", {61'h0, lwe, cwe, rdy}, {61'h0, 3'b101});
    chk("restart_a", {la, ld}, 64'h0000_0030_0000_00CC);

    // Zero-count instance: go goes straight to RUN.
    go_z = 1;
    tick();
    go_z = 0;
    chk("zero_start", {57'h0, ctl_z()}, {57'h0, 7'b0011000});
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("zero_hold%0d", c), {57'h0, ctl_z()}, {57'h0, 7'b0011000});
    end
    chk("zero_ldm", {z_la, z_ld}, 64'h0);
    chk("zero_cfg", {z_ca, z_cd}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
